timer_bank: RTL and testbench
=============================

# timer_bank

Multi-channel programmable timer peripheral on the core's memory-mapped bus. It provides N_CH independent down-scaled up-counters. Each channel has its own prescaler, compare interval, one-shot or periodic mode, a sticky pending flag and an interrupt enable. Channel interrupts feed the interrupt controller as a vector, plus a combined line for single-input cores.

## Interface
- N_CH, 4, number of timer channels (1..16)
- CNT_W, 32, counter/interval width (8..32)
- PRESC_W, 16, prescaler width (0..16; 0 = no prescaler, tick every cycle)
- i_CLK  in  1  system clock
- i_RSTn  in  1  reset, synchronous, active-low
- i_CE  in  1  peripheral chip enable from address decoder
- i_REQ  in  1  bus request
- i_WE  in  1  write enable (1 = write, 0 = read)
- i_ADDR  in  8  byte address; [7:4] channel, [3:2] register, [1:0] ignored
- i_WDATA  in  32  write data
- o_RDATA  out  32  read data, valid in the o_GNT cycle
- o_GNT  out  1  grant = i_REQ & i_CE, combinational
- o_IRQ_VEC  out  N_CH  per-channel interrupt = pending & IE
- o_IRQ  out  1  OR-reduction of o_IRQ_VEC

## Operation
- Per-channel registers, selected by i_ADDR[3:2]:
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE, bits[31:16] PRESC (upper bits beyond PRESC_W read 0).
  - 1 INTERVAL: compare value, CNT_W bits.
  - 2 COUNT: read = current count, zero-extended. A write of any value clears the count and the prescaler.
  - 3 STATUS: bit0 PEND. Write 1 to bit0 clears it; writing 0 has no effect.
- Write happens when i_CE & i_REQ & i_WE. A read is non-destructive.
- Channel index >= N_CH: read returns 0, write is ignored, and o_GNT is still asserted.
- o_RDATA is 0 when o_GNT = 0.
- Write data is truncated to the field width. Reads zero-extend.
- Prescaler: a per-channel counter runs 0..PRESC. tick = EN & (presc_cnt == PRESC), and presc_cnt wraps to 0 on tick. PRESC = 0 ticks every cycle while EN.
- Counter, on tick:
  - If INTERVAL == 0: count held at 0, no event.
  - Else if count == INTERVAL: event. Count goes to 0 and PEND is set. If PERIODIC = 0, EN clears (one-shot).
  - Else count += 1.
- Event period is (INTERVAL+1)*(PRESC+1) cycles.
- EN = 0: prescaler and count freeze at their current values; no events. Setting EN resumes from the frozen values.
- A write to INTERVAL clears count and prescaler in the same cycle.
- PEND is sticky until software clears it. A hardware set in the same cycle as a software clear: set wins, PEND = 1.
- A write to CTRL that sets EN in the same cycle as a one-shot auto-clear of EN: the write wins, EN = 1.
- Reset: all CTRL/INTERVAL/COUNT/prescaler/PEND = 0, so o_IRQ_VEC = 0, o_IRQ = 0, o_RDATA = 0.

## Timing
- o_GNT and o_RDATA are combinational from the bus inputs. Zero-wait-state, single-cycle access.
- Register writes take effect at the clock edge ending the grant cycle.
- Match is evaluated on current count. PEND and o_IRQ_VEC rise at the edge where count wraps to 0. o_IRQ follows combinationally.
- With PRESC = 0 and INTERVAL = K, EN set at edge E0: events at edges E0+(K+1), E0+2(K+1), ...
- Clearing IE masks the IRQ the next cycle but does not clear PEND.
- Reset asserted mid-count: all state returns to reset values at that edge; no event is reported.

## Test plan
- Reset, then read all 4 registers of channel 0 -> all 0; o_IRQ = 0.
- Ch0 INTERVAL = 4, CTRL = 0x7 (EN, PERIODIC, IE, PRESC = 0) -> PEND/o_IRQ_VEC[0] rise 5 cycles after the CTRL write edge, then every 5 cycles. Clear via STATUS write 0x1 -> o_IRQ drops the next cycle.
- Ch1 INTERVAL = 2, CTRL = 0x00030005 (one-shot, IE, PRESC = 3) -> exactly one event, 12 cycles after enable. CTRL then reads EN = 0, and COUNT stays 0.
- Ch2 periodic with INTERVAL = 3: write STATUS = 1 in the exact event cycle -> PEND = 1 (set wins). Also write INTERVAL = 0 -> count stays 0 and no further events.
- Ch3 running, INTERVAL = 100: write CTRL EN = 0 at count 10 -> COUNT reads 10 for 20 cycles. Re-enable -> event after 91 more cycles.
- Access to channel 5 with N_CH = 4 -> o_GNT = 1, o_RDATA = 0, no state change. Pulse i_RSTn low mid-count on all channels -> all registers 0 and no IRQ.

Source files
------------

// File: rtl/timer_bank.sv
// Multi-channel programmable timer: per-channel prescaler, compare interval, one-shot/periodic
// mode, sticky pending flag and interrupt enable, behind a zero-wait-state register bus.
module timer_bank #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic            i_CLK,
  input  logic            i_RSTn,
  input  logic            i_CE,
  input  logic            i_REQ,
  input  logic            i_WE,
  input  logic [7:0]      i_ADDR,
  input  logic [31:0]     i_WDATA,
  output logic [31:0]     o_RDATA,
  output logic            o_GNT,
  output logic [N_CH-1:0] o_IRQ_VEC,
  output logic            o_IRQ
);

  // A zero-width prescaler is modelled as a 1-bit field pinned to zero.
  localparam int unsigned PW = (PRESC_W == 0) ? 1 : PRESC_W;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegIntv   = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;
  localparam logic [1:0] RegStatus = 2'd3;

  logic             en_q       [N_CH];
  logic             en_d       [N_CH];
  logic             periodic_q [N_CH];
  logic             periodic_d [N_CH];
  logic             ie_q       [N_CH];
  logic             ie_d       [N_CH];
  logic             pend_q     [N_CH];
  logic             pend_d     [N_CH];
  logic [PW-1:0]    presc_q    [N_CH];
  logic [PW-1:0]    presc_d    [N_CH];
  logic [PW-1:0]    pcnt_q     [N_CH];
  logic [PW-1:0]    pcnt_d     [N_CH];
  logic [CNT_W-1:0] interval_q [N_CH];
  logic [CNT_W-1:0] interval_d [N_CH];
  logic [CNT_W-1:0] count_q    [N_CH];
  logic [CNT_W-1:0] count_d    [N_CH];

  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  evt;
  logic [N_CH-1:0]  wr_sel;
  logic [3:0]       sel_ch;
  logic [1:0]       sel_reg;
  logic             wr;
  logic [PW-1:0]    wr_presc;
  logic             unused_bits;

  assign sel_ch      = i_ADDR[7:4];
  assign sel_reg     = i_ADDR[3:2];
  assign o_GNT       = i_REQ & i_CE;
  assign wr          = o_GNT & i_WE;
  assign wr_presc    = (PRESC_W == 0) ? '0 : i_WDATA[16 +: PW];
  assign unused_bits = ^{i_ADDR[1:0], i_WDATA};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign wr_sel[g]    = wr && ({28'd0, sel_ch} == 32'(g));
    assign tick[g]      = en_q[g] && (pcnt_q[g] == presc_q[g]);
    assign evt[g]       = tick[g] && (interval_q[g] != '0) && (count_q[g] == interval_q[g]);
    assign o_IRQ_VEC[g] = pend_q[g] & ie_q[g];
  end

  assign o_IRQ = |o_IRQ_VEC;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      en_d[i]       = en_q[i];
      periodic_d[i] = periodic_q[i];
      ie_d[i]       = ie_q[i];
      pend_d[i]     = pend_q[i];
      presc_d[i]    = presc_q[i];
      pcnt_d[i]     = pcnt_q[i];
      interval_d[i] = interval_q[i];
      count_d[i]    = count_q[i];

      if (tick[i]) begin
        pcnt_d[i]  = '0;
        count_d[i] = (interval_q[i] == '0 || evt[i]) ? '0 : count_q[i] + CNT_W'(1);
      end else if (en_q[i]) begin
        pcnt_d[i] = pcnt_q[i] + PW'(1);
      end
      if (evt[i] && !periodic_q[i]) en_d[i] = 1'b0;

      // Bus writes override the hardware update; a set of PEND still beats a clear.
      if (wr_sel[i]) begin
        unique case (sel_reg)
          RegCtrl: begin
            en_d[i]       = i_WDATA[0];
            periodic_d[i] = i_WDATA[1];
            ie_d[i]       = i_WDATA[2];
            presc_d[i]    = wr_presc;
          end
          RegIntv: begin
            interval_d[i] = i_WDATA[CNT_W-1:0];
            count_d[i]    = '0;
            pcnt_d[i]     = '0;
          end
          RegCount: begin
            count_d[i] = '0;
            pcnt_d[i]  = '0;
          end
          RegStatus: begin
            if (i_WDATA[0]) pend_d[i] = 1'b0;
          end
          default: ;
        endcase
      end
      if (evt[i]) pend_d[i] = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!i_RSTn) begin
        en_q[i]       <= 1'b0;
        periodic_q[i] <= 1'b0;
        ie_q[i]       <= 1'b0;
        pend_q[i]     <= 1'b0;
        presc_q[i]    <= '0;
        pcnt_q[i]     <= '0;
        interval_q[i] <= '0;
        count_q[i]    <= '0;
      end else begin
        en_q[i]       <= en_d[i];
        periodic_q[i] <= periodic_d[i];
        ie_q[i]       <= ie_d[i];
        pend_q[i]     <= pend_d[i];
        presc_q[i]    <= presc_d[i];
        pcnt_q[i]     <= pcnt_d[i];
        interval_q[i] <= interval_d[i];
        count_q[i]    <= count_d[i];
      end
    end
  end

  always_comb begin
    o_RDATA = '0;
    if (o_GNT) begin
      for (int i = 0; i < N_CH; i++) begin
        if ({28'd0, sel_ch} == 32'(i)) begin
          unique case (sel_reg)
            RegCtrl: begin
              o_RDATA[2:0]       = {ie_q[i], periodic_q[i], en_q[i]};
              o_RDATA[16 +: PW]  = presc_q[i];
            end
            RegIntv:   o_RDATA = 32'(interval_q[i]);
            RegCount:  o_RDATA = 32'(count_q[i]);
            RegStatus: o_RDATA[0] = pend_q[i];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: event timing, one-shot, set-wins, freeze/resume, decode, reset.
module tb_timer_bank;

  logic        i_CLK;
  logic        i_RSTn;
  logic        i_CE;
  logic        i_REQ;
  logic        i_WE;
  logic [7:0]  i_ADDR;
  logic [31:0] i_WDATA;
  logic [31:0] o_RDATA;
  logic        o_GNT;
  logic [3:0]  o_IRQ_VEC;
  logic        o_IRQ;

  int n_cmp = 0;
  int n_err = 0;

  timer_bank #(.N_CH(4), .CNT_W(32), .PRESC_W(16)) dut (
    .i_CLK     (i_CLK),
    .i_RSTn    (i_RSTn),
    .i_CE      (i_CE),
    .i_REQ     (i_REQ),
    .i_WE      (i_WE),
    .i_ADDR    (i_ADDR),
    .i_WDATA   (i_WDATA),
    .o_RDATA   (o_RDATA),
    .o_GNT     (o_GNT),
    .o_IRQ_VEC (o_IRQ_VEC),
    .o_IRQ     (o_IRQ)
  );

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge i_CLK);
    #1;
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    logic [7:0] a;
    a = {ch[3:0], r[1:0], 2'b00};
    i_CE = 1'b1; i_REQ = 1'b1; i_WE = 1'b1; i_ADDR = a; i_WDATA = d;
    @(posedge i_CLK);
    #1;
    i_REQ = 1'b0; i_WE = 1'b0;
  endtask

  // Combinational peek inside the current cycle; consumes 1ns, no clock edge.
  task automatic chk_rd(input string tag, input int ch, input int r, input logic [31:0] exp);
    logic [7:0] a;
    a = {ch[3:0], r[1:0], 2'b00};
    i_CE = 1'b1; i_REQ = 1'b1; i_WE = 1'b0; i_ADDR = a;
    #1;
    chk(tag, o_RDATA, exp);
  endtask

  initial begin
    i_RSTn = 1'b0; i_CE = 1'b0; i_REQ = 1'b0; i_WE = 1'b0; i_ADDR = '0; i_WDATA = '0;
    step(3);
    i_RSTn = 1'b1;
    step(1);

    // Reset state
    chk_rd("rst_ctrl", 0, 0, 32'h0);
    chk_rd("rst_intv", 0, 1, 32'h0);
    chk_rd("rst_count", 0, 2, 32'h0);
    chk_rd("rst_status", 0, 3, 32'h0);
    chk("rst_irq", {31'd0, o_IRQ}, 32'h0);
    chk("rst_irq_vec", {28'd0, o_IRQ_VEC}, 32'h0);
    step(1);

    // Ch0 periodic, INTERVAL=4, PRESC=0: events every 5 edges after enable
    wr(0, 1, 32'd4);
    wr(0, 0, 32'h7);              // edge E0
    chk_rd("c0_ctrl", 0, 0, 32'h7);
    step(4);
    chk("c0_pre_evt", {28'd0, o_IRQ_VEC}, 32'h0);
    chk_rd("c0_count4", 0, 2, 32'd4);
    step(1);                       // E0+5
    chk("c0_evt1_vec", {28'd0, o_IRQ_VEC}, 32'h1);
    chk("c0_evt1_irq", {31'd0, o_IRQ}, 32'h1);
    chk_rd("c0_evt1_cnt", 0, 2, 32'd0);
    wr(0, 3, 32'h1);               // clear at E0+6
    chk("c0_clr_irq", {31'd0, o_IRQ}, 32'h0);
    chk_rd("c0_clr_st", 0, 3, 32'h0);
    step(3);                       // E0+9
    chk_rd("c0_count_e9", 0, 2, 32'd4);
    chk("c0_pre_evt2", {31'd0, o_IRQ}, 32'h0);
    step(1);                       // E0+10
    chk("c0_evt2_irq", {31'd0, o_IRQ}, 32'h1);
    wr(0, 0, 32'h3);               // drop IE
    chk("c0_ie_mask", {31'd0, o_IRQ}, 32'h0);
    chk_rd("c0_pend_kept", 0, 3, 32'h1);
    wr(0, 0, 32'h0);
    wr(0, 3, 32'h1);

    // Ch1 one-shot, INTERVAL=2, PRESC=3: single event 12 edges after enable
    wr(1, 1, 32'd2);
    wr(1, 0, 32'h0003_0005);       // edge E1
    step(11);
    chk("c1_pre_evt", {28'd0, o_IRQ_VEC}, 32'h0);
    chk_rd("c1_count2", 1, 2, 32'd2);
    step(1);                       // E1+12
    chk("c1_evt_vec", {28'd0, o_IRQ_VEC}, 32'h2);
    chk_rd("c1_ctrl_en0", 1, 0, 32'h0003_0004);
    chk_rd("c1_count0", 1, 2, 32'd0);
    step(20);
    chk_rd("c1_count_hold", 1, 2, 32'd0);
    wr(1, 3, 32'h1);
    chk("c1_clr_irq", {31'd0, o_IRQ}, 32'h0);
    step(20);
    chk_rd("c1_no_second", 1, 3, 32'h0);

    // Ch2 periodic INTERVAL=3: status clear in the event cycle loses to the set
    wr(2, 1, 32'd3);
    wr(2, 0, 32'h7);               // edge E2
    step(4);                       // E2+4
    chk_rd("c2_evt1", 2, 3, 32'h1);
    wr(2, 3, 32'h1);               // E2+5
    chk_rd("c2_clr", 2, 3, 32'h0);
    wr(2, 3, 32'h0);               // E2+6, writing 0 has no effect
    step(1);                       // E2+7
    wr(2, 3, 32'h1);               // E2+8, coincides with event
    chk_rd("c2_set_wins", 2, 3, 32'h1);
    wr(2, 1, 32'd0);
    wr(2, 3, 32'h1);
    step(20);
    chk_rd("c2_int0_count", 2, 2, 32'd0);
    chk_rd("c2_int0_nopend", 2, 3, 32'h0);
    wr(2, 0, 32'h0);

    // Ch3 INTERVAL=100: freeze at 10, resume, event 91 edges later
    wr(3, 1, 32'd100);
    wr(3, 0, 32'h5);               // edge E3
    step(9);
    wr(3, 0, 32'h4);               // E3+10
    chk_rd("c3_frozen", 3, 2, 32'd10);
    step(20);
    chk_rd("c3_frozen20", 3, 2, 32'd10);
    wr(3, 0, 32'h5);               // edge R
    step(90);
    chk_rd("c3_count100", 3, 2, 32'd100);
    chk("c3_pre_evt", {28'd0, o_IRQ_VEC}, 32'h0);
    step(1);
    chk("c3_evt_vec", {28'd0, o_IRQ_VEC}, 32'h8);
    chk_rd("c3_oneshot", 3, 0, 32'h4);

    // Out-of-range channel and idle bus
    i_CE = 1'b1; i_REQ = 1'b1; i_WE = 1'b1; i_ADDR = 8'h54; i_WDATA = 32'h55;
    #1;
    chk("c5_gnt", {31'd0, o_GNT}, 32'h1);
    chk("c5_rdata", o_RDATA, 32'h0);
    @(posedge i_CLK);
    #1;
    i_WE = 1'b0;
    chk_rd("c5_rd", 5, 0, 32'h0);
    chk_rd("c1_intv_kept", 1, 1, 32'd2);
    i_REQ = 1'b0; i_ADDR = 8'h14;
    #1;
    chk("idle_gnt", {31'd0, o_GNT}, 32'h0);
    chk("idle_rdata", o_RDATA, 32'h0);
    step(1);

    // Reset mid-count on all channels
    for (int c = 0; c < 4; c++) wr(c, 1, 32'd50);
    for (int c = 0; c < 4; c++) wr(c, 0, 32'h0002_0007);
    step(10);
    i_RSTn = 1'b0;
    step(1);
    i_RSTn = 1'b1;
    chk("mrst_irq_vec", {28'd0, o_IRQ_VEC}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) chk_rd($sformatf("mrst_c%0d_r%0d", c, r), c, r, 32'h0);
      step(1);
    end
    step(200);
    chk("mrst_no_irq", {31'd0, o_IRQ}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
